// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display blocks.
package display_pkg;

    localparam int          DIGITS     = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef logic [3:0] digit_t;

    // A complete display image: four hex nibbles plus one decimal point per digit.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
    } disp_word_t;

    // Select nibble 'idx' of a 16-bit display value (digit 0 = bits [3:0]).
    function automatic digit_t nibble_of(input logic [15:0] v, input logic [1:0] idx);
        digit_t n;
        case (idx)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            default: n = v[15:12];
        endcase
        return n;
    endfunction

endpackage

// File: rtl/display_scanner_lz_blank_mask.sv
// Leading-zero blank mask for a 4-digit hex value. Bit k is set when digit k
// and every digit above it are zero; digit 0 is never blanked so a value of
// zero still shows a single "0".
module lz_blank_mask (
    input  logic [15:0] value,
    output logic [3:0]  mask
);

    // Zero-run detection from the most significant digit downward.
    always_comb begin
        mask    = 4'b0000;
        mask[3] = (value[15:12] == 4'h0);
        mask[2] = mask[3] && (value[11:8] == 4'h0);
        mask[1] = mask[2] && (value[7:4] == 4'h0);
        mask[0] = 1'b0;
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. A loaded value is staged in 'pend' and only copied into the
// displayed image at a frame boundary, so a frame is never torn.
module display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_pos,
    output logic [3:0]  digit_code,
    output logic [3:0]  anode_n,
    output logic        dp_n,
    output logic [1:0]  digit_idx
);

    localparam int               PRE_W    = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    // Staging and displayed images
    disp_word_t pend_q, pend_d;
    logic       pend_valid_q, pend_valid_d;
    disp_word_t shown_q, shown_d;
    disp_word_t in_word;

    // Scan position; run_q remembers that scanning was active last cycle, so
    // the first enabled edge starts digit 0 with a full-length slot.
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic             run_q, run_d;

    // Registered outputs
    digit_t     digit_code_q, digit_code_d;
    logic [3:0] anode_n_q, anode_n_d;
    logic       dp_n_q, dp_n_d;
    logic [1:0] digit_idx_q, digit_idx_d;

    logic       tick;
    logic       wrap;
    logic       xfer;
    logic       upd;
    logic [3:0] lz_mask;
    logic [3:0] blank_mask;
    digit_t     cur_nib;

    assign in_word = {value, dp_pos};

    // Blank mask for the image that will be displayed after this edge.
    lz_blank_mask u_lz_blank_mask (
        .value (shown_d.value),
        .mask  (lz_mask)
    );

    assign blank_mask = LZ_BLANK ? lz_mask : 4'b0000;

    // Prescaler and digit index: held at zero while disabled, restart on enable.
    always_comb begin
        run_d = run_q;
        pre_d = pre_q;
        idx_d = idx_q;
        tick  = 1'b0;
        if (!enable) begin
            run_d = 1'b0;
            pre_d = '0;
            idx_d = 2'd0;
        end else if (!run_q) begin
            run_d = 1'b1;
            pre_d = '0;
            idx_d = 2'd0;
        end else if (pre_q == PRE_LAST) begin
            tick  = 1'b1;
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            pre_d = pre_q + 1'b1;
        end
        wrap = tick && (idx_q == 2'd3);
        // The image may be replaced at a frame wrap, on the scan start edge,
        // or at any time while the display is blanked.
        xfer = !enable || !run_q || wrap;
        upd  = enable && (!run_q || tick);
    end

    // Load staging and frame-boundary transfer into the displayed image.
    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        shown_d      = shown_q;
        if (xfer) begin
            if (load) begin
                shown_d      = in_word;
                pend_d       = in_word;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                shown_d      = pend_q;
                pend_valid_d = 1'b0;
            end
        end else if (load) begin
            pend_d       = in_word;
            pend_valid_d = 1'b1;
        end
    end

    // Per-digit output decode from the next index and next displayed image.
    always_comb begin
        digit_code_d = digit_code_q;
        anode_n_d    = anode_n_q;
        dp_n_d       = dp_n_q;
        digit_idx_d  = digit_idx_q;
        cur_nib      = nibble_of(shown_d.value, idx_d);
        if (!enable) begin
            digit_code_d = BLANK_CODE;
            anode_n_d    = 4'b1111;
            dp_n_d       = 1'b1;
            digit_idx_d  = 2'd0;
        end else if (upd) begin
            digit_code_d = blank_mask[idx_d] ? BLANK_CODE : cur_nib;
            anode_n_d    = ~(4'b0001 << idx_d);
            dp_n_d       = ~shown_d.dp[idx_d];
            digit_idx_d  = idx_d;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            shown_q      <= '0;
            pre_q        <= '0;
            idx_q        <= 2'd0;
            run_q        <= 1'b0;
            digit_code_q <= BLANK_CODE;
            anode_n_q    <= 4'b1111;
            dp_n_q       <= 1'b1;
            digit_idx_q  <= 2'd0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            shown_q      <= shown_d;
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            run_q        <= run_d;
            digit_code_q <= digit_code_d;
            anode_n_q    <= anode_n_d;
            dp_n_q       <= dp_n_d;
            digit_idx_q  <= digit_idx_d;
        end
    end

    assign digit_code = digit_code_q;
    assign anode_n    = anode_n_q;
    assign dp_n       = dp_n_q;
    assign digit_idx  = digit_idx_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: a driver applies one input vector per clock and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_display_scanner;

    localparam int R  = 4;
    localparam bit LZ = 1'b1;
    localparam int FRAME = 4 * R;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        enable = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] value  = '0;
    logic [3:0]  dp_pos = '0;
    logic [3:0]  digit_code;
    logic [3:0]  anode_n;
    logic        dp_n;
    logic [1:0]  digit_idx;

    display_scanner #(.REFRESH_DIV(R), .LZ_BLANK(LZ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_pos     (dp_pos),
        .digit_code (digit_code),
        .anode_n    (anode_n),
        .dp_n       (dp_n),
        .digit_idx  (digit_idx)
    );

    // Scoreboard: {digit_code, anode_n, dp_n, digit_idx}
    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        done     = 1'b0;

    // Reference model: frame position counted in cycles since scan start.
    bit          m_run;
    int          m_pos;
    logic [15:0] m_shown_v, m_pend_v;
    logic [3:0]  m_shown_dp, m_pend_dp;
    bit          m_pv;

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_pv = 0;
        m_shown_v = '0; m_shown_dp = '0; m_pend_v = '0; m_pend_dp = '0;
    endtask

    task automatic model_edge(input logic e, input logic l, input logic [15:0] v, input logic [3:0] d);
        bit frame_start;
        if (!e) begin
            m_run = 0; m_pos = 0; frame_start = 1;
        end else if (!m_run) begin
            m_run = 1; m_pos = 0; frame_start = 1;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            frame_start = (m_pos == 0);
        end
        if (frame_start) begin
            if (l) begin
                m_shown_v = v; m_shown_dp = d; m_pv = 0;
            end else if (m_pv) begin
                m_shown_v = m_pend_v; m_shown_dp = m_pend_dp; m_pv = 0;
            end
        end else if (l) begin
            m_pend_v = v; m_pend_dp = d; m_pv = 1;
        end
    endtask

    function automatic logic [10:0] model_out(input logic e);
        int          dig;
        logic [15:0] upper;
        logic [3:0]  code;
        logic [3:0]  an;
        if (!e) return {4'hF, 4'b1111, 1'b1, 2'd0};
        dig   = m_pos / R;
        upper = m_shown_v >> (4 * dig);
        code  = (LZ && dig != 0 && upper == 16'h0) ? 4'hF : upper[3:0];
        an    = 4'b1111;
        an[dig] = 1'b0;
        return {code, an, ~m_shown_dp[dig], 2'(dig)};
    endfunction

    // Driver tasks
    task automatic step(input logic e, input logic l, input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        enable = e; load = l; value = v; dp_pos = d;
        @(posedge clk);
        #1;
        model_edge(e, l, v, d);
        exp_q.push_back(model_out(e));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic idle_until(input int pos);
        for (int i = 0; i < FRAME + 2 && m_pos != pos; i++)
            step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        enable = 1'b1; load = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 4))
            0: v = v >> 12;
            1: v = v >> 8;
            2: v = v >> 4;
            default: ;
        endcase
        return v;
    endfunction

    // Monitor: reset values while rst_n is low, scoreboard entries otherwise.
    always begin
        logic [10:0] got, exp;
        @(negedge clk or negedge rst_n);
        got = {digit_code, anode_n, dp_n, digit_idx};
        if (done) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end else if (!rst_n) begin
            #1;
            got = {digit_code, anode_n, dp_n, digit_idx};
            n_checks++;
            if (got !== {4'hF, 4'b1111, 1'b1, 2'd0}) begin
                n_fail++;
                $display("FAIL reset_vals: got code=%h an=%b dp_n=%b idx=%0d, required code=f an=1111 dp_n=1 idx=0",
                         got[10:7], got[6:3], got[2], got[1:0]);
            end
        end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL scan_out @%0t: got code=%h an=%b dp_n=%b idx=%0d, required code=%h an=%b dp_n=%b idx=%0d",
                         $time, got[10:7], got[6:3], got[2], got[1:0], exp[10:7], exp[6:3], exp[2], exp[1:0]);
            end
        end
    end

    // Stimulus
    initial begin
        model_reset();
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic scan of 1234
        step(1'b1, 1'b1, 16'h1234, 4'b0000);
        idle(2 * FRAME);

        // Leading-zero blanking
        step(1'b1, 1'b1, 16'h0005, 4'b0000);
        idle(2 * FRAME);
        step(1'b1, 1'b1, 16'h0000, 4'b0000);
        idle(2 * FRAME);

        // Mid-frame load, then load exactly on the wrap edge
        idle_until(R + 1);
        step(1'b1, 1'b1, 16'hABCD, 4'b0000);
        idle(FRAME + R);
        step(1'b1, 1'b1, 16'h0042, 4'b0001);
        idle_until(FRAME - 1);
        step(1'b1, 1'b1, 16'h5E6D, 4'b0000);
        idle(FRAME + 2);

        // Two loads in one frame: last one wins
        idle_until(2);
        step(1'b1, 1'b1, 16'h1111, 4'b0000);
        idle(3);
        step(1'b1, 1'b1, 16'h2222, 4'b0000);
        idle(2 * FRAME);

        // Disable mid-slot, load while disabled, re-enable
        idle_until(2 * R + 1);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 16'h9087, 4'b1000);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        idle(FRAME + 2);

        // Decimal point on digit 2
        step(1'b1, 1'b1, 16'h3141, 4'b0100);
        idle(2 * FRAME);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), rand_val(), 4'($urandom));
        end

        // Reset mid-frame, then more traffic
        idle_until(R + 2);
        do_reset();
        step(1'b1, 1'b1, 16'h00F7, 4'b0010);
        idle(FRAME + 3);
        for (int i = 0; i < 150; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0), rand_val(), 4'($urandom));
        end

        @(negedge clk);
        #1;
        done = 1'b1;
    end

endmodule
